bus_reg_bank: RTL and testbench
===============================

# bus_reg_bank

Parametrised bank of NREG general-purpose registers, WIDTH bits each, for the bus datapath. It replaces the fixed 16-bit load/increment/clear register with one addressed block. One register per cycle can be loaded, incremented, decremented, shifted or cleared, with a shared overflow flag and wrap or saturate arithmetic. A separate combinational read port drives the bus.

## Interface
- WIDTH, 16, bits per register (≥2)
- NREG, 8, number of registers (≥2; need not be a power of two)
- SAT, 0, arithmetic mode: 0 = wrap-around, 1 = saturate
- AW, $clog2(NREG), address width (derived, not overridden)

- clk  in  1  single clock, rising edge
- clr  in  1  reset, asynchronous, active-high; clears every register and ovf
- sel  in  AW  target register for op
- op   in  3  operation code, sampled on rising clk
- din  in  WIDTH  load data; din[0] / din[WIDTH-1] are shift-in bits
- rsel in  AW  read select
- dout out WIDTH  contents of register rsel (combinational from state)
- zero out 1  dout == 0
- ovf  out 1  registered status flag

## Operation
- Op codes: 000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 CLR, 101 SHL, 110 SHR, 111 CLRALL.
- LOAD: reg[sel] ← din; ovf ← 0.
- INC with SAT=0: reg ← reg+1 mod 2^WIDTH; ovf ← carry out (1 only when reg was all-ones).
- INC with SAT=1: at all-ones, reg holds and ovf ← 1; otherwise reg+1 and ovf ← 0.
- DEC with SAT=0: reg ← reg−1 mod 2^WIDTH; ovf ← borrow (1 only when reg was 0).
- DEC with SAT=1: at 0, reg holds and ovf ← 1; otherwise reg−1 and ovf ← 0.
- CLR: reg[sel] ← 0; ovf ← 0.
- SHL: reg ← {reg[WIDTH-2:0], din[0]}; ovf ← old reg[WIDTH-1].
- SHR: reg ← {din[WIDTH-1], reg[WIDTH-1:1]}; ovf ← old reg[0].
- CLRALL: every register ← 0; ovf ← 0; sel is ignored.
- NOP: all state holds, including ovf.
- Only reg[sel] changes, except on CLRALL.
- Out-of-range sel (sel ≥ NREG), any op except CLRALL and NOP: no register changes, ovf holds.
- Out-of-range rsel: dout = 0 and zero = 1.
- Arithmetic is unsigned, WIDTH bits. Carry and borrow are computed at WIDTH+1 bits, with no truncation warnings.

## Timing
- State updates on the rising clk after op is presented. Latency is 1 cycle.
- dout reflects new state in the same cycle as the edge (combinational read of the array, no bypass).
- Same-cycle write and read to one register (rsel == sel): dout shows the pre-edge value until the edge.
- Asserting clr at any time forces all registers to 0 and ovf to 0 immediately, independent of clk, and overrides any op in flight.
- Reset values: all registers 0, ovf 0, dout 0, zero 1.
- On clr deassertion, the first rising edge executes the op presented then. There is no idle cycle.
- No handshake: one op is accepted every cycle, back-to-back, including repeated INC on the same register.

## Structure
- Shared package bus_pkg holds:
  - the op code localparams: OP_NOP, OP_LOAD, OP_INC, OP_DEC, OP_CLR, OP_SHL, OP_SHR, OP_CLRALL;
  - a 3-bit op typedef.
- Sub-module bus_reg_alu: combinational; inputs current value, op, din and SAT; outputs next value, ovf_next and an ovf_update enable.
  - Instantiated once and shared by the selected register.
- Top holds:
  - the register array;
  - address decode and range check;
  - the read mux;
  - the ovf register.

## Test plan
- Reset: preload via LOAD, assert clr mid-cycle → all regs 0, ovf=0, zero=1 before the next edge; first edge after release executes the presented LOAD.
- Wrap (WIDTH=16, SAT=0): LOAD reg3=16'hFFFF, INC → reg3=0, ovf=1; DEC → 16'hFFFF, ovf=1; INC → 0, ovf=1; INC → 1, ovf=0.
- Saturate (SAT=1): reg2=16'hFFFE, INC, INC, INC → FFFF, FFFF, FFFF with ovf 0, 1, 1; LOAD 0, DEC → 0, ovf=1.
- Shifts: reg1=16'h8001, SHL with din[0]=1 → 16'h0003, ovf=1; SHR with din[15]=1 → 16'h8001, ovf=1.
- Isolation and range: NREG=6; LOAD reg5=16'h1234, op LOAD sel=7 → no register changes, ovf unchanged; rsel=7 → dout=0, zero=1; CLRALL → all 0.
- Same-cycle read: rsel=sel=4, LOAD 16'hABCD → dout shows old value before the edge and ABCD after; back-to-back INC×3 → ABD0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus register bank: op codes and op type.
// Latency: none (definitions only).
// Backpressure: none; the bank accepts one op every cycle.
//
// Op codes are 3 bits wide. OP_CLRALL is the only op that touches more
// than one register. OP_NOP is the only op that leaves ovf untouched for an
// in-range sel.
package bus_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP    = 3'b000;
    localparam op_t OP_LOAD   = 3'b001;
    localparam op_t OP_INC    = 3'b010;
    localparam op_t OP_DEC    = 3'b011;
    localparam op_t OP_CLR    = 3'b100;
    localparam op_t OP_SHL    = 3'b101;
    localparam op_t OP_SHR    = 3'b110;
    localparam op_t OP_CLRALL = 3'b111;

endpackage

// File: rtl/bus_reg_alu.sv
// Next-value/overflow logic for one register of the bus register bank.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports:
//   cur_i     - current value of the selected register
//   op_i      - operation code (bus_pkg::op_t)
//   din_i     - load data; din_i[0] and din_i[WIDTH-1] are the shift-in bits
//   nxt_o     - value the selected register takes on the next edge
//   ovf_nxt_o - value ovf takes when ovf_upd_o is set
//   ovf_upd_o - ovf must be written (low only for NOP)
module bus_reg_alu
    import bus_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] cur_i,
    input  op_t              op_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             ovf_nxt_o,
    output logic             ovf_upd_o
);

    // One extra bit so the carry/borrow falls out of the adder directly.
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;

    assign inc_w = {1'b0, cur_i} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w = {1'b0, cur_i} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        nxt_o     = cur_i;
        ovf_nxt_o = 1'b0;
        ovf_upd_o = 1'b0;
        case (op_i)
            OP_NOP: begin
                // state and ovf hold
            end
            OP_LOAD: begin
                nxt_o     = din_i;
                ovf_upd_o = 1'b1;
            end
            OP_INC: begin
                ovf_upd_o = 1'b1;
                ovf_nxt_o = inc_w[WIDTH];
                // In saturate mode an overflowing increment keeps the value.
                if (!(SAT && inc_w[WIDTH])) begin
                    nxt_o = inc_w[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                ovf_upd_o = 1'b1;
                ovf_nxt_o = dec_w[WIDTH];
                if (!(SAT && dec_w[WIDTH])) begin
                    nxt_o = dec_w[WIDTH-1:0];
                end
            end
            OP_CLR, OP_CLRALL: begin
                nxt_o     = '0;
                ovf_upd_o = 1'b1;
            end
            OP_SHL: begin
                nxt_o     = {cur_i[WIDTH-2:0], din_i[0]};
                ovf_nxt_o = cur_i[WIDTH-1];
                ovf_upd_o = 1'b1;
            end
            OP_SHR: begin
                nxt_o     = {din_i[WIDTH-1], cur_i[WIDTH-1:1]};
                ovf_nxt_o = cur_i[0];
                ovf_upd_o = 1'b1;
            end
            default: begin
                nxt_o     = cur_i;
                ovf_upd_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_reg_bank.sv
// Addressed bank of NREG registers with load/inc/dec/shift/clear and a shared ovf flag.
// Latency: writes take effect on the next rising clk; the read port is combinational.
// Backpressure: none; one op is accepted every cycle, back-to-back.
//
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-high clear of all registers and ovf
//   sel  - target register for op
//   op   - operation code (bus_pkg::op_t)
//   din  - load data / shift-in bits
//   rsel - read select
//   dout - contents of register rsel, 0 when rsel is out of range
//   zero - dout == 0
//   ovf  - registered overflow/carry/borrow/shift-out flag
module bus_reg_bank
    import bus_pkg::*;
#(
    parameter int   WIDTH = 16,
    parameter int   NREG  = 8,
    parameter bit   SAT   = 1'b0,
    localparam int  AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [AW-1:0]    sel,
    input  op_t              op,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    rsel,
    output logic [WIDTH-1:0] dout,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             ovf_q;
    logic             ovf_d;

    logic             sel_ok;
    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] alu_nxt;
    logic             alu_ovf_nxt;
    logic             alu_ovf_upd;

    // NREG need not be a power of two, so sel can name a register that
    // does not exist.
    assign sel_ok = (int'(sel) < NREG);

    // Value of the selected register; an unmatched sel yields 0, and that
    // result is discarded because sel_ok gates the write-back.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == AW'(i)) begin
                cur_val = regs_q[i];
            end
        end
    end

    bus_reg_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .cur_i     (cur_val),
        .op_i      (op),
        .din_i     (din),
        .nxt_o     (alu_nxt),
        .ovf_nxt_o (alu_ovf_nxt),
        .ovf_upd_o (alu_ovf_upd)
    );

    always_comb begin
        regs_d = regs_q;
        ovf_d  = ovf_q;
        if (op == OP_CLRALL) begin
            // Broadcast clear ignores sel entirely.
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
            ovf_d = 1'b0;
        end else if (sel_ok) begin
            for (int i = 0; i < NREG; i++) begin
                if (sel == AW'(i)) begin
                    regs_d[i] = alu_nxt;
                end
            end
            if (alu_ovf_upd) begin
                ovf_d = alu_ovf_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    // Read port straight off the array: a same-cycle write to rsel shows
    // up only after the edge.
    always_comb begin
        dout = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rsel == AW'(i)) begin
                dout = regs_q[i];
            end
        end
    end

    assign zero = (dout == '0);
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Bench for bus_reg_bank: a wrap-mode bank (NREG=6) and a saturate-mode bank (NREG=8)
// share one stimulus stream; an arithmetic model predicts both and is checked every
// negedge, with literal expectations after each directed step.
module tb_bus_reg_bank;

    localparam logic [2:0] T_NOP    = 3'd0;
    localparam logic [2:0] T_LOAD   = 3'd1;
    localparam logic [2:0] T_INC    = 3'd2;
    localparam logic [2:0] T_DEC    = 3'd3;
    localparam logic [2:0] T_CLR    = 3'd4;
    localparam logic [2:0] T_SHL    = 3'd5;
    localparam logic [2:0] T_SHR    = 3'd6;
    localparam logic [2:0] T_CLRALL = 3'd7;

    logic        clk  = 1'b0;
    logic        clr  = 1'b1;
    logic [2:0]  sel  = 3'd0;
    logic [2:0]  op   = 3'd0;
    logic [15:0] din  = 16'd0;
    logic [2:0]  rsel = 3'd0;

    logic [15:0] dout_w, dout_s;
    logic        zero_w, zero_s, ovf_w, ovf_s;

    int total = 0;
    int bad   = 0;

    // model state: index 0 = wrap bank, 1 = saturate bank
    int m [2][8];
    int mo [2];
    int nreg [2] = '{6, 8};
    int msat [2] = '{0, 1};

    bus_reg_bank #(.WIDTH(16), .NREG(6), .SAT(1'b0)) u_wrap (
        .clk(clk), .clr(clr), .sel(sel), .op(op), .din(din), .rsel(rsel),
        .dout(dout_w), .zero(zero_w), .ovf(ovf_w)
    );

    bus_reg_bank #(.WIDTH(16), .NREG(8), .SAT(1'b1)) u_sat (
        .clk(clk), .clr(clr), .sel(sel), .op(op), .din(din), .rsel(rsel),
        .dout(dout_s), .zero(zero_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_dout(input int d);
        if (int'(rsel) < nreg[d]) return m[d][rsel];
        return 0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m[d][i] = 0;
            mo[d] = 0;
        end
    endtask

    // Applies the op on the bench inputs to both models, as of a rising edge.
    task automatic model_edge();
        int v;
        int o;
        int s;
        if (clr) begin
            model_clear();
            return;
        end
        s = int'(sel);
        for (int d = 0; d < 2; d++) begin
            if (op == T_CLRALL) begin
                for (int i = 0; i < 8; i++) m[d][i] = 0;
                mo[d] = 0;
            end else if (op != T_NOP && s < nreg[d]) begin
                v = m[d][s];
                o = 0;
                case (op)
                    T_LOAD: v = int'(din);
                    T_INC: begin
                        if (v == 65535) begin
                            o = 1;
                            if (msat[d] == 0) v = 0;
                        end else v = v + 1;
                    end
                    T_DEC: begin
                        if (v == 0) begin
                            o = 1;
                            if (msat[d] == 0) v = 65535;
                        end else v = v - 1;
                    end
                    T_CLR: v = 0;
                    T_SHL: begin
                        o = (v >= 32768) ? 1 : 0;
                        v = (v * 2 + int'(din) % 2) % 65536;
                    end
                    T_SHR: begin
                        o = v % 2;
                        v = v / 2 + ((int'(din) >= 32768) ? 32768 : 0);
                    end
                    default: ;
                endcase
                m[d][s] = v;
                mo[d] = o;
            end
        end
    endtask

    task automatic set_in(input logic [2:0] o, input logic [2:0] s,
                          input logic [15:0] dv, input logic [2:0] rs);
        op = o; sel = s; din = dv; rsel = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic [2:0] o, input logic [2:0] s,
                        input logic [15:0] dv, input logic [2:0] rs);
        set_in(o, s, dv, rs);
        tick();
    endtask

    // Hand-computed expectations for both banks.
    task automatic lit(input string n, input int wd, input int wo, input int sd, input int so);
        check({n, "_w_dout"}, int'(dout_w), wd);
        check({n, "_w_ovf"},  int'(ovf_w),  wo);
        check({n, "_s_dout"}, int'(dout_s), sd);
        check({n, "_s_ovf"},  int'(ovf_s),  so);
    endtask

    // Every-cycle comparison against the model, just before the next edge.
    always @(negedge clk) begin
        check("cmp_w_dout", int'(dout_w), exp_dout(0));
        check("cmp_w_zero", int'(zero_w), (exp_dout(0) == 0) ? 1 : 0);
        check("cmp_w_ovf",  int'(ovf_w),  mo[0]);
        check("cmp_s_dout", int'(dout_s), exp_dout(1));
        check("cmp_s_zero", int'(zero_s), (exp_dout(1) == 0) ? 1 : 0);
        check("cmp_s_ovf",  int'(ovf_s),  mo[1]);
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 0, 0, 0, 0);
        check("reset_w_zero", int'(zero_w), 1);
        check("reset_s_zero", int'(zero_s), 1);
        clr = 1'b0;

        // preload, then async clear mid-cycle with a LOAD already presented
        step(T_LOAD, 3'd3, 16'hFFFF, 3'd3); lit("pre_load", 16'hFFFF, 0, 16'hFFFF, 0);
        step(T_INC,  3'd3, 16'h0000, 3'd3); lit("pre_inc",  16'h0000, 1, 16'hFFFF, 1);
        set_in(T_LOAD, 3'd2, 16'h2222, 3'd3);
        #2;
        clr = 1'b1;
        model_clear();
        #1;
        lit("clr_async", 0, 0, 0, 0);
        check("clr_w_zero", int'(zero_w), 1);
        check("clr_s_zero", int'(zero_s), 1);
        #2;
        clr = 1'b0;
        rsel = 3'd2;
        tick();
        lit("clr_release_load", 16'h2222, 0, 16'h2222, 0);

        // wrap sequence on reg3
        step(T_LOAD, 3'd3, 16'hFFFF, 3'd3); lit("wrap_load", 16'hFFFF, 0, 16'hFFFF, 0);
        step(T_INC,  3'd3, 16'h0000, 3'd3); lit("wrap_inc1", 16'h0000, 1, 16'hFFFF, 1);
        step(T_DEC,  3'd3, 16'h0000, 3'd3); lit("wrap_dec",  16'hFFFF, 1, 16'hFFFE, 0);
        step(T_INC,  3'd3, 16'h0000, 3'd3); lit("wrap_inc2", 16'h0000, 1, 16'hFFFF, 0);
        step(T_INC,  3'd3, 16'h0000, 3'd3); lit("wrap_inc3", 16'h0001, 0, 16'hFFFF, 1);

        // saturate sequence on reg2
        step(T_LOAD, 3'd2, 16'hFFFE, 3'd2); lit("sat_load", 16'hFFFE, 0, 16'hFFFE, 0);
        step(T_INC,  3'd2, 16'h0000, 3'd2); lit("sat_inc1", 16'hFFFF, 0, 16'hFFFF, 0);
        step(T_INC,  3'd2, 16'h0000, 3'd2); lit("sat_inc2", 16'h0000, 1, 16'hFFFF, 1);
        step(T_INC,  3'd2, 16'h0000, 3'd2); lit("sat_inc3", 16'h0001, 0, 16'hFFFF, 1);
        step(T_LOAD, 3'd2, 16'h0000, 3'd2); lit("sat_load0", 16'h0000, 0, 16'h0000, 0);
        step(T_DEC,  3'd2, 16'h0000, 3'd2); lit("sat_dec0", 16'hFFFF, 1, 16'h0000, 1);

        // shifts on reg1
        step(T_LOAD, 3'd1, 16'h8001, 3'd1); lit("sh_load", 16'h8001, 0, 16'h8001, 0);
        step(T_SHL,  3'd1, 16'h0001, 3'd1); lit("shl_in1", 16'h0003, 1, 16'h0003, 1);
        step(T_SHR,  3'd1, 16'h8000, 3'd1); lit("shr_in1", 16'h8001, 1, 16'h8001, 1);
        step(T_SHR,  3'd1, 16'h0000, 3'd1); lit("shr_in0", 16'h4000, 1, 16'h4000, 1);
        step(T_SHL,  3'd1, 16'h0000, 3'd1); lit("shl_in0", 16'h8000, 0, 16'h8000, 0);
        step(T_CLR,  3'd1, 16'hFFFF, 3'd1); lit("clr_one", 16'h0000, 0, 16'h0000, 0);

        // isolation and range: sel 6/7 exist only in the 8-register bank
        step(T_LOAD, 3'd5, 16'h1234, 3'd5); lit("iso_load5", 16'h1234, 0, 16'h1234, 0);
        step(T_LOAD, 3'd0, 16'hFFFF, 3'd0);
        step(T_INC,  3'd0, 16'h0000, 3'd0); lit("iso_ovf_set", 16'h0000, 1, 16'hFFFF, 1);
        step(T_LOAD, 3'd7, 16'h5555, 3'd5); lit("iso_sel7", 16'h1234, 1, 16'h1234, 0);
        step(T_NOP,  3'd0, 16'h0000, 3'd7); lit("iso_rsel7", 16'h0000, 1, 16'h5555, 0);
        check("iso_rsel7_w_zero", int'(zero_w), 1);
        step(T_INC,  3'd6, 16'h0000, 3'd6); lit("iso_inc6", 16'h0000, 1, 16'h0001, 0);
        step(T_NOP,  3'd3, 16'h0000, 3'd3); lit("iso_nop", 16'h0001, 1, 16'hFFFF, 0);
        step(T_CLRALL, 3'd7, 16'hFFFF, 3'd5); lit("clrall", 16'h0000, 0, 16'h0000, 0);
        step(T_NOP,  3'd0, 16'h0000, 3'd7); lit("clrall_r7", 16'h0000, 0, 16'h0000, 0);
        step(T_NOP,  3'd0, 16'h0000, 3'd3); lit("clrall_r3", 16'h0000, 0, 16'h0000, 0);

        // same-cycle write and read of reg4, then back-to-back increments
        step(T_LOAD, 3'd4, 16'h1111, 3'd4); lit("same_pre", 16'h1111, 0, 16'h1111, 0);
        set_in(T_LOAD, 3'd4, 16'hABCD, 3'd4);
        #1;
        lit("same_before_edge", 16'h1111, 0, 16'h1111, 0);
        tick();
        lit("same_after_edge", 16'hABCD, 0, 16'hABCD, 0);
        step(T_INC, 3'd4, 16'h0000, 3'd4); lit("b2b_inc1", 16'hABCE, 0, 16'hABCE, 0);
        step(T_INC, 3'd4, 16'h0000, 3'd4); lit("b2b_inc2", 16'hABCF, 0, 16'hABCF, 0);
        step(T_INC, 3'd4, 16'h0000, 3'd4); lit("b2b_inc3", 16'hABD0, 0, 16'hABD0, 0);
        check("b2b_w_zero", int'(zero_w), 0);
        step(T_NOP, 3'd0, 16'h0000, 3'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
